noc_traffic_node: RTL and testbench

- Parametrised NoC traffic generator and checker endpoint; attaches to one router local port in place of a processing element.
- Sends PKT_NUM packets (header, PAYLOAD_LEN body flits, tail) to a fixed destination, round-robin over VC_NUM virtual channels, with a configurable inter-packet gap.
- Checks every received packet per VC for framing, destination and body ordering; exposes transmit, receive and error counters for the bench.

---
 rtl/noc_traffic_node.sv | 237 +++++++++++++++++++++++
 tb/tb_noc_traffic_node.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_traffic_node.sv
// NoC endpoint: generates a fixed run of packets towards one destination and
// checks framing, destination and body ordering of everything it receives.
//
// TX state | meaning
// TX_IDLE  | no run started yet
// TX_HEAD  | presenting header flit
// TX_BODY  | presenting body flits 0..PAYLOAD_LEN-1
// TX_TAIL  | presenting tail flit
// TX_GAP   | valid held low between packets
// TX_DONE  | run complete, tx_done high
// RX (per VC): rx_in_pkt=0 waiting for header, rx_in_pkt=1 inside a packet

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 4
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 4
`endif
`ifndef Noc_Head_H
`define Noc_Head_H 4'hA
`endif
`ifndef Noc_Head_E
`define Noc_Head_E 4'h5
`endif
`ifndef Noc_Tail_H
`define Noc_Tail_H 4'hC
`endif
`ifndef Noc_Tail_E
`define Noc_Tail_E 4'h3
`endif

module noc_traffic_node #(
  parameter logic [`Noc_ID_X_Width-1:0] X_ID      = '0,
  parameter logic [`Noc_ID_Y_Width-1:0] Y_ID      = '0,
  parameter logic [`Noc_ID_X_Width-1:0] DEST_X_ID = '0,
  parameter logic [`Noc_ID_Y_Width-1:0] DEST_Y_ID = '0,
  parameter int VC_NUM      = 2,
  parameter int PKT_NUM     = 51,
  parameter int PAYLOAD_LEN = 1,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                       noc_clk,
  input  logic                       noc_rst_n,
  input  logic                       tx_start,
  input  logic                       rx_enable,
  output logic                       sender_valid,
  input  logic                       sender_ready,
  output logic [`Noc_Data_Width-1:0] sender_flit,
  output logic                       sender_is_header,
  output logic                       sender_is_tail,
  output logic [VC_NUM-1:0]          sender_vc,
  input  logic [VC_NUM-1:0]          receive_valid,
  output logic [VC_NUM-1:0]          receive_ready,
  input  logic [`Noc_Data_Width-1:0] receive_flit,
  input  logic                       receive_is_header,
  input  logic                       receive_is_tail,
  output logic [15:0]                tx_pkt_cnt,
  output logic [15:0]                rx_pkt_cnt,
  output logic [15:0]                err_cnt,
  output logic                       tx_done
);

  localparam logic [15:0] PKT_TOTAL = 16'(PKT_NUM);
  localparam logic [7:0]  BODY_LAST = 8'(PAYLOAD_LEN - 1);
  localparam logic [8:0]  BODY_LEN  = 9'(PAYLOAD_LEN);
  localparam logic [7:0]  GAP_LOAD  = 8'(GAP_CYCLES - 1);
  localparam logic [2:0]  VC_LAST   = 3'(VC_NUM - 1);
  localparam int DY_LSB = 12;
  localparam int DX_LSB = DY_LSB + `Noc_ID_Y_Width;
  localparam logic [`Noc_Data_Width-1:0] HDR_FLIT =
    {`Noc_Head_H, X_ID, Y_ID, DEST_X_ID, DEST_Y_ID, 4'h0, `Noc_Head_E, 4'h0};
  localparam logic [`Noc_Data_Width-1:0] TAIL_FLIT =
    {`Noc_Tail_H, X_ID, Y_ID, DEST_X_ID, DEST_Y_ID, 4'h0, `Noc_Tail_E, 4'h0};

  typedef enum logic [2:0] {TX_IDLE, TX_HEAD, TX_BODY, TX_TAIL, TX_GAP, TX_DONE} tx_state_t;

  tx_state_t         tx_state, tx_next;
  logic [15:0]       pkt_left;
  logic [7:0]        body_idx;
  logic [7:0]        gap_cnt;
  logic [2:0]        vc_idx;
  logic [VC_NUM-1:0] vc_oh;
  logic              start_run;

  assign start_run = tx_start && (tx_state == TX_IDLE || tx_state == TX_DONE);
  assign tx_done   = (tx_state == TX_DONE);

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) tx_state <= TX_IDLE;
    else            tx_state <= tx_next;
  end

  // Outputs depend only on registered state, so they hold until the handshake.
  always_comb begin
    tx_next          = tx_state;
    sender_valid     = 1'b0;
    sender_is_header = 1'b0;
    sender_is_tail   = 1'b0;
    sender_flit      = '0;
    vc_oh            = '0;
    for (int v = 0; v < VC_NUM; v++) vc_oh[v] = (vc_idx == 3'(v));
    case (tx_state)
      TX_IDLE, TX_DONE: if (tx_start) tx_next = (PKT_NUM == 0) ? TX_DONE : TX_HEAD;
      TX_HEAD: begin
        sender_valid     = 1'b1;
        sender_is_header = 1'b1;
        sender_flit      = HDR_FLIT;
        if (sender_ready) tx_next = TX_BODY;
      end
      TX_BODY: begin
        sender_valid      = 1'b1;
        sender_flit[15:8] = tx_pkt_cnt[7:0];
        sender_flit[7:0]  = body_idx;
        if (sender_ready && body_idx == BODY_LAST) tx_next = TX_TAIL;
      end
      TX_TAIL: begin
        sender_valid   = 1'b1;
        sender_is_tail = 1'b1;
        sender_flit    = TAIL_FLIT;
        if (sender_ready) begin
          if (pkt_left == 16'd1)   tx_next = TX_DONE;
          else if (GAP_CYCLES > 0) tx_next = TX_GAP;
          else                     tx_next = TX_HEAD;
        end
      end
      TX_GAP:  if (gap_cnt == 8'd0) tx_next = TX_HEAD;
      default: tx_next = TX_IDLE;
    endcase
    sender_vc = sender_valid ? vc_oh : '0;
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      tx_pkt_cnt <= '0;
      pkt_left   <= '0;
      body_idx   <= '0;
      gap_cnt    <= '0;
      vc_idx     <= '0;
    end else if (start_run) begin
      tx_pkt_cnt <= '0;
      pkt_left   <= PKT_TOTAL;
      body_idx   <= '0;
      vc_idx     <= '0;
    end else begin
      case (tx_state)
        TX_HEAD: if (sender_ready) body_idx <= '0;
        TX_BODY: if (sender_ready) body_idx <= body_idx + 8'd1;
        TX_TAIL: if (sender_ready) begin
          tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
          pkt_left   <= pkt_left - 16'd1;
          vc_idx     <= (vc_idx == VC_LAST) ? 3'd0 : vc_idx + 3'd1;
          gap_cnt    <= GAP_LOAD;
        end
        TX_GAP:  if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
        default: ;
      endcase
    end
  end

  logic [VC_NUM-1:0]      rx_acc, rx_sel, rx_in_pkt, rx_flag;
  logic [VC_NUM-1:0][8:0] rx_cnt;
  logic                   cur_in, cur_flag, nxt_in, nxt_flag;
  logic [8:0]             cur_cnt, nxt_cnt;
  logic                   dest_ok, pkt_ok, flit_err, rx_evt, err_evt;
  logic                   unused_flit_bits;

  assign unused_flit_bits = ^{receive_flit[`Noc_Data_Width-1:DX_LSB+`Noc_ID_X_Width],
                              receive_flit[DY_LSB-1:8]};

  // Only the lowest accepted VC is processed; the rest of the beat is discarded.
  always_comb begin
    rx_acc   = receive_valid & receive_ready;
    rx_sel   = '0;
    cur_in   = 1'b0;
    cur_flag = 1'b0;
    cur_cnt  = '0;
    for (int v = VC_NUM - 1; v >= 0; v--) begin
      if (rx_acc[v]) begin
        rx_sel    = '0;
        rx_sel[v] = 1'b1;
        cur_in    = rx_in_pkt[v];
        cur_flag  = rx_flag[v];
        cur_cnt   = rx_cnt[v];
      end
    end
    dest_ok  = (receive_flit[DX_LSB +: `Noc_ID_X_Width] == X_ID) &&
               (receive_flit[DY_LSB +: `Noc_ID_Y_Width] == Y_ID);
    nxt_in   = cur_in;
    nxt_flag = cur_flag;
    nxt_cnt  = cur_cnt;
    pkt_ok   = 1'b0;
    flit_err = 1'b0;
    if (receive_is_header) begin
      flit_err = cur_in;
      nxt_in   = 1'b1;
      nxt_cnt  = '0;
      nxt_flag = !dest_ok;
    end else if (receive_is_tail) begin
      if (cur_in && cur_cnt == BODY_LEN && !cur_flag) pkt_ok = 1'b1;
      else                                             flit_err = 1'b1;
      nxt_in = 1'b0;
    end else if (cur_in) begin
      nxt_flag = cur_flag || (receive_flit[7:0] != cur_cnt[7:0]) || cur_cnt[8];
      if (!cur_cnt[8]) nxt_cnt = cur_cnt + 9'd1;
    end else begin
      flit_err = 1'b1;
    end
    rx_evt  = (rx_acc != '0) && pkt_ok;
    err_evt = (rx_acc != '0) && (flit_err || $countones(rx_acc) > 1);
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      receive_ready <= '0;
      rx_in_pkt     <= '0;
      rx_flag       <= '0;
      rx_cnt        <= '0;
      rx_pkt_cnt    <= '0;
      err_cnt       <= '0;
    end else begin
      receive_ready <= {VC_NUM{rx_enable}};
      for (int v = 0; v < VC_NUM; v++) begin
        if (rx_sel[v]) begin
          rx_in_pkt[v] <= nxt_in;
          rx_flag[v]   <= nxt_flag;
          rx_cnt[v]    <= nxt_cnt;
        end
      end
      if (rx_evt) rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
      if (err_evt && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_noc_traffic_node.sv
// Bench for noc_traffic_node: loopback runs with random backpressure checked
// against a flit-list model, plus injected receive traffic with known outcomes.

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 4
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 4
`endif
`ifndef Noc_Head_H
`define Noc_Head_H 4'hA
`endif
`ifndef Noc_Head_E
`define Noc_Head_E 4'h5
`endif
`ifndef Noc_Tail_H
`define Noc_Tail_H 4'hC
`endif
`ifndef Noc_Tail_E
`define Noc_Tail_E 4'h3
`endif

module tb_noc_traffic_node;
  localparam logic [3:0] XI = 4'd1;
  localparam logic [3:0] YI = 4'd2;
  localparam int VCN  = 2;
  localparam int PKTN = 4;
  localparam int PLEN = 3;
  localparam int GAPN = 2;

  logic        noc_clk = 1'b0;
  logic        noc_rst_n = 1'b0;
  logic        tx_start = 1'b0;
  logic        rx_enable = 1'b0;
  logic        sender_ready = 1'b0;
  logic        sender_valid, sender_is_header, sender_is_tail, tx_done;
  logic [31:0] sender_flit, receive_flit;
  logic [1:0]  sender_vc, receive_valid, receive_ready;
  logic        receive_is_header, receive_is_tail;
  logic [15:0] tx_pkt_cnt, rx_pkt_cnt, err_cnt;

  logic        loop_mode = 1'b1;
  logic [1:0]  inj_valid = '0;
  logic [31:0] inj_flit = '0;
  logic        inj_hdr = 1'b0, inj_tail = 1'b0;

  assign receive_valid     = loop_mode ? ((sender_valid && sender_ready) ? sender_vc : 2'b00) : inj_valid;
  assign receive_flit      = loop_mode ? sender_flit : inj_flit;
  assign receive_is_header = loop_mode ? sender_is_header : inj_hdr;
  assign receive_is_tail   = loop_mode ? sender_is_tail : inj_tail;

  noc_traffic_node #(
    .X_ID(XI), .Y_ID(YI), .DEST_X_ID(XI), .DEST_Y_ID(YI),
    .VC_NUM(VCN), .PKT_NUM(PKTN), .PAYLOAD_LEN(PLEN), .GAP_CYCLES(GAPN)
  ) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .tx_start(tx_start), .rx_enable(rx_enable),
    .sender_valid(sender_valid), .sender_ready(sender_ready), .sender_flit(sender_flit),
    .sender_is_header(sender_is_header), .sender_is_tail(sender_is_tail), .sender_vc(sender_vc),
    .receive_valid(receive_valid), .receive_ready(receive_ready), .receive_flit(receive_flit),
    .receive_is_header(receive_is_header), .receive_is_tail(receive_is_tail),
    .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt), .err_cnt(err_cnt), .tx_done(tx_done)
  );

  always #5 noc_clk = ~noc_clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] flit;
    logic        hdr;
    logic        tail;
    logic [1:0]  vc;
  } flit_t;

  flit_t       exp_q[$];
  flit_t       mon_e;
  int          tails_seen = 0;
  bit          run_active = 1'b0;
  bit          in_gap = 1'b0;
  int          gap_count = 0;
  bit          prev_valid = 1'b0, prev_hs = 1'b0;
  logic [31:0] prev_flit;
  logic [3:0]  prev_mark;
  int          exp_rx = 0, exp_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hdr_flit(input logic [3:0] dx, input logic [3:0] dy);
    return {`Noc_Head_H, XI, YI, dx, dy, 4'h0, `Noc_Head_E, 4'h0};
  endfunction

  function automatic logic [31:0] tail_flit();
    return {`Noc_Tail_H, XI, YI, XI, YI, 4'h0, `Noc_Tail_E, 4'h0};
  endfunction

  // Expected transmit stream for one whole run, straight from the packet format.
  task automatic build_run();
    exp_q.delete();
    for (int k = 0; k < PKTN; k++) begin
      exp_q.push_back('{hdr_flit(XI, YI), 1'b1, 1'b0, 2'(1 << (k % VCN))});
      for (int i = 0; i < PLEN; i++)
        exp_q.push_back('{{16'h0, 8'(k), 8'(i)}, 1'b0, 1'b0, 2'(1 << (k % VCN))});
      exp_q.push_back('{tail_flit(), 1'b0, 1'b1, 2'(1 << (k % VCN))});
    end
  endtask

  task automatic start_pulse();
    @(posedge noc_clk); #1;
    run_active = 1'b0;
    tx_start = 1'b1;
    @(posedge noc_clk); #1;
    tx_start = 1'b0;
    tails_seen = 0;
    run_active = 1'b1;
  endtask

  task automatic wait_done(input string tag, input bit random_ready);
    for (int c = 0; c < 3000 && !tx_done; c++) begin
      @(posedge noc_clk); #1;
      if (random_ready) sender_ready = ($urandom_range(0, 3) != 0);
    end
    chk(tag, tx_done, 1'b1);
  endtask

  task automatic inject(input logic [1:0] vm, input logic [31:0] f, input logic h, input logic t);
    @(posedge noc_clk); #1;
    inj_valid = vm; inj_flit = f; inj_hdr = h; inj_tail = t;
    @(posedge noc_clk); #1;
    inj_valid = '0; inj_hdr = 1'b0; inj_tail = 1'b0;
  endtask

  function automatic logic [31:0] rbody(input int idx);
    logic [31:0] r;
    r = $urandom;
    return {r[23:0], 8'(idx)};
  endfunction

  task automatic send_bodies(input logic [1:0] vm, input int n, input bit swap);
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = i;
      if (swap && i == 1) idx = 2;
      if (swap && i == 2) idx = 1;
      inject(vm, rbody(idx), 1'b0, 1'b0);
    end
  endtask

  // Each kind leaves the VC waiting for a header, so the outcome is known up front.
  task automatic send_pkt(input int kind, input int vc);
    logic [1:0] vm;
    vm = 2'(1 << vc);
    case (kind)
      0: begin inject(vm, hdr_flit(XI, YI), 1, 0); send_bodies(vm, PLEN, 0);
               inject(vm, tail_flit(), 0, 1); exp_rx++; end
      1: begin inject(vm, hdr_flit(XI + 4'd1, YI), 1, 0); send_bodies(vm, PLEN, 0);
               inject(vm, tail_flit(), 0, 1); exp_err++; end
      2: begin inject(vm, hdr_flit(XI, YI), 1, 0); send_bodies(vm, PLEN - 1, 0);
               inject(vm, tail_flit(), 0, 1); exp_err++; end
      3: begin inject(vm, hdr_flit(XI, YI), 1, 0); send_bodies(vm, PLEN + 1, 0);
               inject(vm, tail_flit(), 0, 1); exp_err++; end
      4: begin inject(vm, hdr_flit(XI, YI), 1, 0); send_bodies(vm, PLEN, 1);
               inject(vm, tail_flit(), 0, 1); exp_err++; end
      5: begin inject(vm, rbody(0), 0, 0); exp_err++; end
      6: begin inject(vm, hdr_flit(XI, YI), 1, 0); inject(vm, hdr_flit(XI, YI), 1, 0);
               send_bodies(vm, PLEN, 0); inject(vm, tail_flit(), 0, 1);
               exp_err++; exp_rx++; end
      default: begin inject(vm, tail_flit(), 0, 1); exp_err++; end
    endcase
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_rx"}, rx_pkt_cnt, 16'(exp_rx));
    chk({tag, "_err"}, err_cnt, 16'(exp_err));
  endtask

  always @(negedge noc_clk) begin
    if (!noc_rst_n || !run_active) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      in_gap     = 1'b0;
    end else begin
      chk("tx_done", tx_done, tails_seen == PKTN);
      chk("tx_pkt_cnt", tx_pkt_cnt, tails_seen);
      if (prev_valid && !prev_hs) begin
        chk("hold_valid", sender_valid, 1'b1);
        chk("hold_flit", sender_flit, prev_flit);
        chk("hold_marks", {sender_is_header, sender_is_tail, sender_vc}, prev_mark);
      end
      if (in_gap) begin
        if (sender_valid) begin
          chk("gap_len", gap_count, GAPN);
          in_gap = 1'b0;
        end else gap_count++;
      end
      if (sender_valid && sender_ready) begin
        chk("flit_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("flit", sender_flit, mon_e.flit);
          chk("is_header", sender_is_header, mon_e.hdr);
          chk("is_tail", sender_is_tail, mon_e.tail);
          chk("vc", sender_vc, mon_e.vc);
          if (mon_e.tail) begin
            tails_seen++;
            if (tails_seen < PKTN) begin in_gap = 1'b1; gap_count = 0; end
          end
        end
      end
      prev_valid = sender_valid;
      prev_hs    = sender_valid && sender_ready;
      prev_flit  = sender_flit;
      prev_mark  = {sender_is_header, sender_is_tail, sender_vc};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    repeat (3) @(posedge noc_clk);
    #1;
    chk("rst_valid", sender_valid, 1'b0);
    chk("rst_flit", sender_flit, 32'h0);
    chk("rst_vc", sender_vc, 2'b00);
    chk("rst_ready", receive_ready, 2'b00);
    chk("rst_counts", {tx_pkt_cnt, rx_pkt_cnt}, 32'h0);
    chk("rst_err_done", {err_cnt, 15'h0, tx_done}, 32'h0);

    noc_rst_n = 1'b1;
    rx_enable = 1'b1;
    @(posedge noc_clk); #1;
    chk("ready_latency", receive_ready, 2'b11);

    // Run 1: loopback with random backpressure.
    build_run();
    start_pulse();
    wait_done("run1_done", 1'b1);
    @(posedge noc_clk); #1;
    chk("run1_tx", tx_pkt_cnt, 16'(PKTN));
    chk("run1_rx", rx_pkt_cnt, 16'(PKTN));
    chk("run1_err", err_cnt, 16'h0);
    chk("run1_drained", exp_q.size(), 0);

    // Run 2: restart from DONE, stall 4 cycles while body flit 1 is presented.
    sender_ready = 1'b1;
    build_run();
    start_pulse();
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (sender_valid && !sender_is_header && !sender_is_tail && sender_flit[7:0] == 8'd1)
        found = 1'b1;
      else begin @(posedge noc_clk); #1; end
    end
    chk("b1_seen", found, 1'b1);
    sender_ready = 1'b0;
    repeat (4) @(posedge noc_clk);
    #1;
    chk("stall_flit", sender_flit, 32'h0000_0001);
    chk("stall_valid", sender_valid, 1'b1);
    sender_ready = 1'b1;
    wait_done("run2_done", 1'b0);
    @(posedge noc_clk); #1;
    chk("run2_tx", tx_pkt_cnt, 16'(PKTN));
    chk("run2_rx", rx_pkt_cnt, 16'(2 * PKTN));
    chk("run2_err", err_cnt, 16'h0);

    // Injected receive traffic.
    run_active = 1'b0;
    loop_mode  = 1'b0;
    sender_ready = 1'b0;
    exp_rx = 2 * PKTN;
    exp_err = 0;
    send_pkt(1, 0); check_rx("bad_dest");
    send_pkt(2, 0); check_rx("short_body");
    send_pkt(5, 0); check_rx("orphan_body");
    send_pkt(6, 1); check_rx("double_hdr");

    inject(2'b11, rbody(0), 1'b0, 1'b0);
    exp_err++; check_rx("multi_body");
    inject(2'b11, hdr_flit(XI, YI), 1'b1, 1'b0);
    exp_err++; check_rx("multi_hdr");
    send_bodies(2'b01, PLEN, 0);
    inject(2'b01, tail_flit(), 1'b0, 1'b1);
    exp_rx++; check_rx("multi_finish");
    send_pkt(0, 1); check_rx("vc1_clean");

    inject(2'b01, hdr_flit(XI, YI), 1'b1, 1'b0);
    inject(2'b10, hdr_flit(XI, YI), 1'b1, 1'b0);
    for (int i = 0; i < PLEN; i++) begin
      inject(2'b10, rbody(i), 1'b0, 1'b0);
      inject(2'b01, rbody(i), 1'b0, 1'b0);
    end
    inject(2'b01, tail_flit(), 1'b0, 1'b1);
    inject(2'b10, tail_flit(), 1'b0, 1'b1);
    exp_rx += 2; check_rx("interleave");

    for (int n = 0; n < 40; n++) begin
      send_pkt($urandom_range(0, 7), $urandom_range(0, 1));
      check_rx("random");
    end

    // Run 3: reset during the body of packet 3, then a fresh run.
    loop_mode = 1'b1;
    sender_ready = 1'b1;
    build_run();
    start_pulse();
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      if (tails_seen == 2 && sender_valid && !sender_is_header && !sender_is_tail)
        found = 1'b1;
      else begin @(posedge noc_clk); #1; end
    end
    chk("pkt3_body_seen", found, 1'b1);
    run_active = 1'b0;
    noc_rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx_pkt_cnt, 16'h0);
    chk("mid_rst_rx", rx_pkt_cnt, 16'h0);
    chk("mid_rst_err", err_cnt, 16'h0);
    chk("mid_rst_out", {sender_valid, sender_vc, tx_done, receive_ready}, 6'h0);
    @(posedge noc_clk); #1;
    noc_rst_n = 1'b1;
    @(posedge noc_clk); #1;
    build_run();
    start_pulse();
    chk("fresh_hdr", {sender_valid, sender_is_header, sender_vc}, 4'b1101);
    wait_done("run3_done", 1'b0);
    @(posedge noc_clk); #1;
    chk("run3_tx", tx_pkt_cnt, 16'(PKTN));
    chk("run3_rx", rx_pkt_cnt, 16'(PKTN));
    chk("run3_err", err_cnt, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
